// File: rtl/msg_validator_if.sv
`default_nettype none
// ============================================================================
// Module      : msg_validator_if
// Description : Start/finish handshake and message-RAM read port bundle for
//               the message validator.
// Revision    : 1.0 - initial release
// ============================================================================
interface msg_validator_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                  start;
  logic                  finish;
  logic                  msg_ok;
  logic [ADDR_WIDTH-1:0] bad_idx;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_q;

  // Validator side: takes start and RAM data, returns result and address
  modport slave (
    input  start,
    input  rd_q,
    output finish,
    output msg_ok,
    output bad_idx,
    output rd_addr
  );

  // Controller/RAM side
  modport master (
    output start,
    output rd_q,
    input  finish,
    input  msg_ok,
    input  bad_idx,
    input  rd_addr
  );
endinterface
`default_nettype wire

// File: rtl/msg_validator.sv
`default_nettype none
// ============================================================================
// Module      : msg_validator
// Description : Scans the decrypted-message RAM and checks every byte is a
//               lowercase letter or space. Aborts on the first bad byte and
//               reports its index. Four-phase start/finish handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module msg_validator #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    ADDR_WIDTH  = 8,
  parameter int                    MESSAGE_LEN = 32,
  parameter logic [DATA_WIDTH-1:0] CHAR_LO     = 8'h61,
  parameter logic [DATA_WIDTH-1:0] CHAR_HI     = 8'h7A,
  parameter logic [DATA_WIDTH-1:0] CHAR_SP     = 8'h20
) (
  input  logic              clk,
  input  logic              rst,
  msg_validator_if.slave    bus
);

  // k is one bit wider than the address so a full 2^ADDR_WIDTH message
  // can be indexed without the last-byte compare wrapping.
  localparam logic [ADDR_WIDTH:0] c_LAST = (ADDR_WIDTH+1)'(MESSAGE_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH:0]   r_k;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic                  r_finish;
  logic                  r_msg_ok;
  logic [ADDR_WIDTH-1:0] r_bad_idx;
  logic                  w_accept;

  // Plausible plaintext: 'a'..'z' or space (unsigned compares)
  assign w_accept = ((bus.rd_q >= CHAR_LO) && (bus.rd_q <= CHAR_HI)) ||
                    (bus.rd_q == CHAR_SP);

  // Scan FSM; rd_addr tracks the low bits of k, and every RAM read needs a
  // wait state because both the address and the RAM output are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_k       <= '0;
      r_rd_addr <= '0;
      r_finish  <= 1'b0;
      r_msg_ok  <= 1'b0;
      r_bad_idx <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_finish <= 1'b0;
          if (bus.start) begin
            r_k       <= '0;
            r_rd_addr <= '0;
            r_msg_ok  <= 1'b0;
            r_bad_idx <= '0;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          if (!w_accept) begin
            r_msg_ok  <= 1'b0;
            r_bad_idx <= r_k[ADDR_WIDTH-1:0];
            r_finish  <= 1'b1;
            r_state   <= S_DONE;
          end else if (r_k == c_LAST) begin
            r_msg_ok  <= 1'b1;
            r_bad_idx <= '0;
            r_finish  <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_k       <= r_k + 1'b1;
            r_rd_addr <= r_rd_addr + 1'b1;
            r_state   <= S_WAIT;
          end
        end
        S_DONE: begin
          // Results stay put until the controller drops start
          if (!bus.start) begin
            r_finish <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: begin
          r_finish <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.finish  = r_finish;
  assign bus.msg_ok  = r_msg_ok;
  assign bus.bad_idx = r_bad_idx;
  assign bus.rd_addr = r_rd_addr;

endmodule
`default_nettype wire

// File: tb/tb_msg_validator.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_msg_validator
// Description : Scoreboard bench for msg_validator with a behavioural RAM
//               and a first-bad-byte reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_msg_validator;
  localparam int DW  = 8;
  localparam int AW  = 8;
  localparam int LEN = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  msg_validator_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  msg_validator #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .MESSAGE_LEN(LEN),
    .CHAR_LO    (8'h61),
    .CHAR_HI    (8'h7A),
    .CHAR_SP    (8'h20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Message RAM with registered read data
  logic [7:0] mem [0:255];
  always @(posedge clk) bus.rd_q <= mem[bus.rd_addr];

  typedef struct {
    bit ok;
    int bad;
    int fin;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   scan_active = 1'b0;
  bit   done_seen   = 1'b0;
  bit   prev_fin    = 1'b0;
  int   scan_e, scan_fin, scan_last;

  // Posedge counter used to time latency
  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit plausible(input logic [7:0] b);
    return (b inside {[8'h61:8'h7A]}) || (b == 8'h20);
  endfunction

  function automatic logic [7:0] rand_good();
    int v;
    v = $urandom_range(0, 26);
    return (v == 26) ? 8'h20 : 8'(8'h61 + v);
  endfunction

  function automatic logic [7:0] rand_bad();
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    while (plausible(b)) b = 8'($urandom_range(0, 255));
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < 256; i++)
      mem[i] = (i >= LEN) ? 8'hFF : ((i % 27 == 26) ? 8'h20 : 8'(8'h61 + (i % 27)));
  endtask

  // Reference model: first byte in 0..LEN-1 that is not plausible
  task automatic launch();
    exp_t x;
    int   last;
    bit   ok;
    ok   = 1'b1;
    last = LEN - 1;
    for (int i = 0; i < LEN; i++) begin
      if (!plausible(mem[i])) begin
        ok   = 1'b0;
        last = i;
        break;
      end
    end
    @(negedge clk);
    scan_e    = cyc + 1;
    scan_last = last;
    scan_fin  = scan_e + 2 * (last + 1);
    x.ok  = ok;
    x.bad = ok ? 0 : last;
    x.fin = scan_fin;
    sbq.push_back(x);
    done_seen   = 1'b0;
    scan_active = 1'b1;
    bus.start   = 1'b1;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done_seen && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!done_seen) begin
      total++;
      bad++;
      $display("FAIL wait_done: no finish seen after %0d cycles", n);
      scan_active = 1'b0;
    end
  endtask

  task automatic run_pass();
    launch();
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    repeat (2) @(negedge clk);
  endtask

  // Monitor: address trace, clear-on-start, and scoreboard pop on finish
  always begin
    @(posedge clk);
    #1;
    if (scan_active) begin
      if (cyc >= scan_e && cyc <= scan_fin)
        check("rd_addr", bus.rd_addr,
              ((cyc - scan_e) / 2 < scan_last) ? (cyc - scan_e) / 2 : scan_last);
      if (cyc == scan_e) begin
        check("msg_ok_clear", bus.msg_ok, 0);
        check("bad_idx_clear", bus.bad_idx, 0);
        check("finish_low", bus.finish, 0);
      end
      if (bus.finish === 1'b1 && !prev_fin) begin
        mon_e = sbq.pop_front();
        check("latency", cyc, mon_e.fin);
        check("msg_ok", bus.msg_ok, mon_e.ok);
        check("bad_idx", bus.bad_idx, mon_e.bad);
        scan_active = 1'b0;
        done_seen   = 1'b1;
      end else if (cyc > scan_fin) begin
        total++;
        bad++;
        $display("FAIL finish_timeout: got finish=%0b expected 1 by cycle %0d", bus.finish, scan_fin);
        if (sbq.size() > 0) void'(sbq.pop_front());
        scan_active = 1'b0;
        done_seen   = 1'b1;
      end
    end else if (bus.finish === 1'b1 && !prev_fin) begin
      check("unexpected_finish", 1, 0);
    end
    prev_fin = (bus.finish === 1'b1);
  end

  // Directed and random stimulus
  initial begin
    bus.start = 1'b0;
    fill_pattern();
    repeat (3) @(negedge clk);
    check("rst_finish", bus.finish, 0);
    check("rst_msg_ok", bus.msg_ok, 0);
    check("rst_bad_idx", bus.bad_idx, 0);
    check("rst_rd_addr", bus.rd_addr, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Fully valid message
    run_pass();

    // Bad first byte
    mem[0] = 8'h41;
    run_pass();
    fill_pattern();

    // Boundary bytes at index 5
    begin
      logic [7:0] vals [6];
      vals = '{8'h60, 8'h7B, 8'h1F, 8'h61, 8'h7A, 8'h20};
      for (int i = 0; i < 6; i++) begin
        mem[5] = vals[i];
        run_pass();
      end
    end
    fill_pattern();

    // Bad last byte
    mem[31] = 8'hFF;
    run_pass();
    fill_pattern();

    // Reset mid-scan at edge E+17
    launch();
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < scan_e + 16) @(negedge clk);
    scan_active = 1'b0;
    void'(sbq.pop_front());
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_finish", bus.finish, 0);
    check("midrst_msg_ok", bus.msg_ok, 0);
    check("midrst_bad_idx", bus.bad_idx, 0);
    check("midrst_rd_addr", bus.rd_addr, 0);
    @(negedge clk);
    run_pass();

    // Handshake: hold start through DONE, then drop and rerun with new data
    launch();
    wait_done();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_finish", bus.finish, 1);
      check("hold_rd_addr", bus.rd_addr, LEN - 1);
    end
    bus.start = 1'b0;
    @(negedge clk);
    check("drop_finish", bus.finish, 0);
    mem[3] = 8'h2E;
    run_pass();
    fill_pattern();

    // Random messages, about two thirds with one or more corrupted bytes
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < LEN; i++) mem[i] = rand_good();
      if ($urandom_range(0, 2) != 0) begin
        int nbad;
        nbad = $urandom_range(1, 3);
        for (int j = 0; j < nbad; j++) mem[$urandom_range(0, LEN - 1)] = rand_bad();
      end
      run_pass();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit
  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire

// File: doc/msg_validator.md
Name: msg_validator

Overview:
- Reads the decrypted-message RAM written by the RC4 decrypter and checks whether every byte is plausible plaintext: lowercase 'a'..'z' or space.
- Reports pass/fail plus the index of the first offending byte.
- Aborts early on the first bad byte, so the key-search controller can reject a candidate key without scanning the whole message.
- Sits between the decrypted-message RAM (read port) and the key-search controller (start/finish handshake).

Parameters:
DATA_WIDTH, 8, byte width of message RAM (fixed at 8)
ADDR_WIDTH, 8, message RAM address width
MESSAGE_LEN, 32, number of bytes to check (1..2^ADDR_WIDTH)
CHAR_LO, 8'h61, lowest accepted letter ('a')
CHAR_HI, 8'h7A, highest accepted letter ('z')
CHAR_SP, 8'h20, additional accepted byte (space)

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
start  input  1  request a check pass; sampled in IDLE
finish  output  1  high while in DONE; result outputs valid
msg_ok  output  1  1 = all MESSAGE_LEN bytes accepted; qualified by finish
bad_idx  output  ADDR_WIDTH  index of first rejected byte; 0 when msg_ok=1
rd_addr  output  ADDR_WIDTH  message RAM read address, registered
rd_q  input  DATA_WIDTH  message RAM read data

Behaviour:
- Reset (clk and rst are decided: rst synchronous, active-high, clock clk): state=IDLE, k=0, rd_addr=0, finish=0, msg_ok=0, bad_idx=0. Reset takes priority in every state, including mid-scan.
- RAM timing: rd_addr is registered and the RAM registers its output. rd_q is therefore valid two edges after rd_addr is updated, which requires one wait state per byte.
- Byte acceptance: (CHAR_LO <= rd_q <= CHAR_HI) or (rd_q == CHAR_SP). Compare unsigned.
- IDLE: finish=0.
  - If start=1: k<=0, rd_addr<=0, msg_ok<=0, bad_idx<=0, go WAIT.
  - Otherwise hold.
- WAIT: one-cycle RAM latency, then go CHECK.
- CHECK: rd_q holds byte k.
  - Rejected: msg_ok<=0, bad_idx<=k, go DONE (early abort).
  - Accepted, k < MESSAGE_LEN-1: k<=k+1, rd_addr<=k+1, go WAIT.
  - Accepted, k == MESSAGE_LEN-1: msg_ok<=1, bad_idx<=0, go DONE.
- DONE: finish=1; msg_ok and bad_idx are held stable.
  - Leave for IDLE only when start=0 (four-phase handshake).
  - start held high keeps DONE; no auto-restart.
- Latency: start sampled at edge E. For a fully valid message, finish rises after edge E+2*MESSAGE_LEN (64 for the default). For a first bad byte at index b, finish rises after edge E+2*(b+1).
- k counter is ADDR_WIDTH+1 bits so MESSAGE_LEN = 2^ADDR_WIDTH cannot wrap; rd_addr is the low ADDR_WIDTH bits.
- rd_addr never exceeds MESSAGE_LEN-1. rd_addr holds its last value in DONE and IDLE.
- No writes to the RAM; the block is read-only.
- start is ignored in WAIT, CHECK and DONE; only IDLE samples it.
- Back-to-back passes: drop start in DONE, re-raise in IDLE. A new pass clears msg_ok and bad_idx on leaving IDLE.

Test Plan:
- RAM = 32 x 'a'..'z' cycling with spaces; pulse start -> finish=1 after exactly 64 edges, msg_ok=1, bad_idx=0, rd_addr sequence 0..31 with each value held 2 cycles.
- RAM[0]=8'h41 ('A'), rest valid -> finish after 2 edges, msg_ok=0, bad_idx=0, rd_addr never left 0.
- Boundary bytes: RAM[5]=8'h60, then rerun with RAM[5]=8'h7B, then with RAM[5]=8'h1F -> each pass fails with bad_idx=5. Rerun with RAM[5] set to each of 8'h61, 8'h7A, 8'h20 -> each pass gives msg_ok=1.
- RAM[31]=8'hFF only -> finish after 64 edges, msg_ok=0, bad_idx=31.
- rst asserted for one cycle at edge E+17 of a scan -> next cycle state IDLE, finish=0, msg_ok=0, rd_addr=0. A subsequent start scans from byte 0 and gives the correct result.
- Handshake: hold start high through DONE for 10 cycles -> finish stays 1, no rescan. Drop start -> IDLE one edge later. Raise start with RAM modified -> new result reflects new contents; msg_ok clears on leaving IDLE.
